mod5_check_tx: RTL and testbench
================================

MOD5_CHECK_TX -- requirements
Module: mod5_check_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: payload width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-003 The block SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1: upstream offers in_data.
REQ-005 The block SHALL have port in_ready, output, 1: block can accept a payload this cycle.
REQ-006 The block SHALL have port in_data, input, DATA_W: payload, unsigned, sampled only on acceptance.
REQ-007 The block SHALL have port tx_bit, output, 1: serial stream bit, MSB-first.
REQ-008 The block SHALL have port tx_valid, output, 1: tx_bit carries a frame bit this cycle.
REQ-009 The block SHALL have port tx_last, output, 1: final bit of the current frame.

Function
REQ-010 The block SHALL emit frames of DATA_W+3 bits whose value, read MSB-first as an unsigned integer, is an exact multiple of 5.
REQ-011 Frame content SHALL be in_data (DATA_W bits, MSB first) followed by 3 check bits K (MSB first).
REQ-012 K SHALL equal (2*(in_data mod 5)) mod 5, giving K = 0,2,4,1,3 for remainders 0,1,2,3,4.
REQ-013 States SHALL be IDLE, DATA, CHECK.
REQ-014 in_ready SHALL be 1 exactly when state is IDLE; it SHALL be registered with no combinational path from in_valid.
REQ-015 Acceptance SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is latched into a shift register and state goes IDLE->DATA.
REQ-016 Latency: if acceptance occurs at edge E, the first data bit SHALL appear on tx_bit/tx_valid in the cycle after E, i.e. outputs are registered.
REQ-017 DATA SHALL last exactly DATA_W cycles, one bit per cycle, then go to CHECK.
REQ-018 CHECK SHALL last exactly 3 cycles, then go to IDLE; tx_last=1 only in the third CHECK cycle.
REQ-019 A running remainder r (3 bits, 0..4) SHALL be cleared on acceptance and updated per data bit b as r <= (2*r + b) mod 5; values 5..7 SHALL never occur.
REQ-020 K SHALL be derived from r after the last data bit is included, and SHALL be stable on tx_bit at the first CHECK cycle with no bubble.
REQ-021 tx_valid SHALL be 1 in every DATA and CHECK cycle and 0 in IDLE; tx_bit and tx_last SHALL be 0 whenever tx_valid=0.
REQ-022 Consecutive frames SHALL be separated by at least one IDLE cycle; throughput is 1 frame per DATA_W+4 cycles with in_valid held high.
REQ-023 in_valid and in_data changes during DATA/CHECK SHALL be ignored and SHALL NOT alter the frame in flight.
REQ-024 tx_valid has no backpressure; the block SHALL transmit unconditionally once a frame is accepted.

Reset
REQ-025 While resetn=0 at a rising edge: state SHALL become IDLE, r=0, shift register=0, tx_valid=0, tx_bit=0, tx_last=0, in_ready=1 in the following cycle.
REQ-026 Reset mid-frame SHALL abort the frame immediately with no tx_last; a payload offered during the reset cycle SHALL NOT be accepted.
REQ-027 After reset release the first acceptance SHALL be possible at the first edge with resetn=1.

Verification (DATA_W=8)
REQ-028 in_data=0x07 (r=2) -> stream 00000111 100, tx_last on bit 11, value 60.
REQ-029 in_data=0x01 (r=1) -> 00000001 010 (value 10); in_data=0x03 -> 00000011 001 (value 25).
REQ-030 in_data=0xFF (r=0) -> 11111111 000 (value 2040); in_data=0x00 -> 11 zeros, tx_valid high 11 cycles.
REQ-031 in_valid held high with 0x07 then 0x03 -> two frames, exactly one IDLE cycle between them, in_ready low for 11 cycles per frame, in_data toggled mid-frame has no effect.
REQ-032 resetn=0 at DATA bit 4 -> next cycle tx_valid=0, in_ready=1, no tx_last; next frame 0x01 correct per REQ-029.
REQ-033 Random sweep of all 256 payloads, back-to-back -> every frame 11 bits, value mod 5 = 0; a serial mod-5 checker fed tx_bit with per-frame restart reports remainder 0 exactly at each tx_last.

Source files
------------

// File: rtl/mod5_check_tx.sv
// mod5_check_tx: serialises each accepted payload MSB-first, then appends
// 3 check bits so the whole DATA_W+3 bit frame is a multiple of 5.
//   clk, resetn      : rising-edge clock, synchronous active-low reset
//   in_valid/in_ready: payload handshake (in_ready registered, high in IDLE)
//   in_data          : payload, latched on acceptance
//   tx_bit/tx_valid  : registered serial stream, one frame bit per cycle
//   tx_last          : marks the final check bit of the frame
module mod5_check_tx #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_last
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sr, sr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        r, r_nxt;
  logic [1:0]        chk, chk_nxt;
  logic              in_ready_nxt, tx_bit_nxt, tx_valid_nxt, tx_last_nxt;

  logic              accept_c;
  logic              data_done_c;
  logic              check_done_c;
  logic [2:0]        r_upd_c;
  logic [2:0]        k_c;

  // One step of the serial remainder: (2*rem + b) mod 5, result stays 0..4.
  function automatic logic [2:0] mod5_step(input logic [2:0] rem, input logic b);
    logic [3:0] t;
    t = {rem, 1'b0} + {3'b000, b};
    return (t >= 4'd5) ? 3'(t - 4'd5) : t[2:0];
  endfunction

  assign accept_c     = in_valid && in_ready;
  assign data_done_c  = (cnt == CNT_W'(DATA_W - 1));
  assign check_done_c = (cnt == CNT_W'(2));
  // r folds in the bit currently on tx_bit; K = 2*r mod 5 once the LSB is in.
  assign r_upd_c      = mod5_step(r, tx_bit);
  assign k_c          = mod5_step(r_upd_c, 1'b0);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c)     state_nxt = DATA;
      DATA:    if (data_done_c)  state_nxt = CHECK;
      CHECK:   if (check_done_c) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Output/datapath logic: next values of the registered outputs and datapath.
  always_comb begin
    in_ready_nxt = 1'b0;
    tx_valid_nxt = 1'b0;
    tx_bit_nxt   = 1'b0;
    tx_last_nxt  = 1'b0;
    sr_nxt       = sr;
    cnt_nxt      = cnt;
    r_nxt        = r;
    chk_nxt      = chk;
    case (state)
      IDLE: begin
        if (accept_c) begin
          // MSB goes straight to the output register; the rest waits in sr.
          tx_valid_nxt = 1'b1;
          tx_bit_nxt   = in_data[DATA_W-1];
          sr_nxt       = {in_data[DATA_W-2:0], 1'b0};
          cnt_nxt      = '0;
          r_nxt        = '0;
        end else begin
          in_ready_nxt = 1'b1;
        end
      end
      DATA: begin
        tx_valid_nxt = 1'b1;
        r_nxt        = r_upd_c;
        if (data_done_c) begin
          // Check bits follow the last data bit with no gap.
          tx_bit_nxt = k_c[2];
          chk_nxt    = k_c[1:0];
          cnt_nxt    = '0;
        end else begin
          tx_bit_nxt = sr[DATA_W-1];
          sr_nxt     = {sr[DATA_W-2:0], 1'b0};
          cnt_nxt    = cnt + CNT_W'(1);
        end
      end
      CHECK: begin
        if (check_done_c) begin
          in_ready_nxt = 1'b1;
        end else begin
          tx_valid_nxt = 1'b1;
          tx_bit_nxt   = (cnt == CNT_W'(0)) ? chk[1] : chk[0];
          tx_last_nxt  = (cnt == CNT_W'(1));
          cnt_nxt      = cnt + CNT_W'(1);
        end
      end
      default: in_ready_nxt = 1'b1;
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      in_ready <= 1'b1;
      tx_valid <= 1'b0;
      tx_bit   <= 1'b0;
      tx_last  <= 1'b0;
      sr       <= '0;
      cnt      <= '0;
      r        <= '0;
      chk      <= '0;
    end else begin
      in_ready <= in_ready_nxt;
      tx_valid <= tx_valid_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_last  <= tx_last_nxt;
      sr       <= sr_nxt;
      cnt      <= cnt_nxt;
      r        <= r_nxt;
      chk      <= chk_nxt;
    end
  end

endmodule

// File: tb/tb_mod5_check_tx.sv
// tb_mod5_check_tx: random/directed stimulus for mod5_check_tx with a
// scoreboard of expected frame values and a negedge monitor that checks the
// serial stream, handshake, frame spacing and reset behaviour.
module tb_mod5_check_tx;

  localparam int unsigned W   = 8;
  localparam int          FLEN = W + 3;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         tx_bit, tx_valid, tx_last;

  int ncmp = 0;
  int nerr = 0;

  int q[$];
  int cur = 0;
  int idx = 0;
  int rem = 0;
  int cyc = 0;
  int prev_tl = -1;
  bit b2b = 1'b0;
  bit chk_rst = 1'b0;
  bit exp_start = 1'b0;

  mod5_check_tx #(.DATA_W(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .tx_bit   (tx_bit),
    .tx_valid (tx_valid),
    .tx_last  (tx_last)
  );

  always #5 clk = ~clk;

  // Reference: payload shifted by 3 plus the unique K in 0..4 that makes it divisible by 5.
  function automatic int frame_of(input int d);
    int base;
    base = d * 8;
    return base + ((5 - (base % 5)) % 5);
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (chk_rst) begin
      cmp("reset_tx_valid", int'(tx_valid), 0);
      cmp("reset_tx_bit",   int'(tx_bit),   0);
      cmp("reset_tx_last",  int'(tx_last),  0);
      cmp("reset_in_ready", int'(in_ready), 1);
      chk_rst = 1'b0;
    end else begin
      if (exp_start) begin
        cmp("latency_valid", int'(tx_valid), 1);
        cmp("latency_first_bit_idx", idx, 0);
      end
      cmp("in_ready_vs_idle", int'(in_ready), int'(!tx_valid));
      if (tx_valid) begin
        if (idx == 0) begin
          if (q.size() == 0) begin
            cmp("unexpected_frame", 1, 0);
            cur = 0;
          end else begin
            cur = q.pop_front();
          end
          if (b2b && prev_tl >= 0) cmp("idle_gap", cyc - prev_tl, 2);
          rem = 0;
        end
        cmp("tx_bit", int'(tx_bit), (cur >> (FLEN - 1 - idx)) & 1);
        cmp("tx_last", int'(tx_last), int'(idx == FLEN - 1));
        rem = (2 * rem + int'(tx_bit)) % 5;
        if (tx_last) begin
          cmp("serial_rem_at_last", rem, 0);
          prev_tl = cyc;
        end
        idx = (idx == FLEN - 1) ? 0 : idx + 1;
      end else begin
        cmp("idle_bit_last", int'(tx_bit) + int'(tx_last), 0);
        if (idx != 0) begin
          cmp("truncated_frame_idx", idx, 0);
          idx = 0;
        end
      end
    end
    exp_start = 1'b0;
    if (!b2b) prev_tl = -1;
    if (!resetn) begin
      chk_rst = 1'b1;
      idx = 0;
      q.delete();
    end else if (in_valid && in_ready) begin
      q.push_back(frame_of(int'(in_data)));
      exp_start = 1'b1;
    end
  end

  // Offer p and return just after the accepting edge; in_data is junk while busy.
  task automatic send(input logic [W-1:0] p);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      in_data = W'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) cmp("accept_timeout", guard, 0);
    in_data = p;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) cmp("idle_timeout", guard, 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic send_single(input logic [W-1:0] p);
    send(p);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] perm [256];
    logic [W-1:0] tmp;
    int j;

    resetn = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed frames, one at a time.
    send_single(8'h07);
    send_single(8'h01);
    send_single(8'h03);
    send_single(8'hFF);
    send_single(8'h00);

    // in_valid held high across two frames with data toggling mid-frame.
    b2b = 1'b1;
    send(8'h07);
    send(8'h03);
    in_valid = 1'b0;
    wait_idle();
    b2b = 1'b0;
    @(posedge clk); #1;

    // Reset during DATA bit 4 with a payload offered in the reset cycle.
    send(8'h07);
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    resetn   = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(posedge clk); #1;
    resetn = 1'b1;
    send_single(8'h01);

    // All 256 payloads in random order, back-to-back.
    for (int i = 0; i < 256; i++) perm[i] = W'(i);
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    b2b = 1'b1;
    for (int i = 0; i < 256; i++) send(perm[i]);
    in_valid = 1'b0;
    wait_idle();
    b2b = 1'b0;

    cmp("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
